pellet_tracker: RTL and testbench

- Consumes the player position (playerX/playerY, 10-bit pixel coordinates, updated once per frame_clk) produced by the player movement stage.
- Holds a 32x24 pellet bitmap on the 20-pixel tile grid. Clears a pellet when the player's tile contains one, and keeps the BCD score and the remaining-pellet count.
- Provides a combinational pixel query, pellet_on, that the colour mapper uses to draw pellets. Raises level_clear when every pellet has been eaten.

---
 rtl/pellet_tracker.sv | 127 ++++++++++++
 tb/tb_pellet_tracker.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pellet_tracker.sv
// Pellet bitmap, score and remaining-count tracker on the 20-pixel tile grid.
// Player tiles are registered one edge before they are checked against the map.
module pellet_tracker #(
    parameter logic [9:0] PELLET_COUNT = 10'd400,
    parameter logic [4:0] DOT_LO       = 5'd8,
    parameter logic [4:0] DOT_HI       = 5'd11
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        level_restart,
    input  logic [9:0]  playerX,
    input  logic [9:0]  playerY,
    input  logic [9:0]  drawX,
    input  logic [9:0]  drawY,
    output logic        pellet_on,
    output logic [15:0] score_bcd,
    output logic [9:0]  remaining,
    output logic        eat,
    output logic        level_clear
);

    function automatic logic [9:0] div20(input logic [9:0] v);
        return v / 10'd20;
    endfunction

    // Saturating 4-digit BCD increment.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (c) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    logic [767:0] r_map;
    logic [9:0]   r_tile_q;
    logic         r_valid_q;
    logic [15:0]  r_score;
    logic [9:0]   r_remaining;
    logic         r_eat;
    logic         r_level_clear;

    // Quotient bounds double as the on-screen test: col < 32 <=> X < 640, row < 24 <=> Y < 480.
    logic [9:0] w_pq_x, w_pq_y;
    logic       w_p_valid;
    logic [9:0] w_p_tile;

    assign w_pq_x    = div20(playerX);
    assign w_pq_y    = div20(playerY);
    assign w_p_valid = (w_pq_x < 10'd32) && (w_pq_y < 10'd24);
    assign w_p_tile  = {w_pq_y[4:0], w_pq_x[4:0]};

    logic [9:0] w_dq_x, w_dq_y;
    logic [9:0] w_dr_x, w_dr_y;
    logic       w_d_valid;
    logic [9:0] w_d_idx;
    logic       w_dot_x, w_dot_y;

    assign w_dq_x    = div20(drawX);
    assign w_dq_y    = div20(drawY);
    assign w_dr_x    = drawX - w_dq_x * 10'd20;
    assign w_dr_y    = drawY - w_dq_y * 10'd20;
    assign w_d_valid = (w_dq_x < 10'd32) && (w_dq_y < 10'd24);
    assign w_d_idx   = w_d_valid ? {w_dq_y[4:0], w_dq_x[4:0]} : 10'd0;
    assign w_dot_x   = (w_dr_x >= {5'd0, DOT_LO}) && (w_dr_x <= {5'd0, DOT_HI});
    assign w_dot_y   = (w_dr_y >= {5'd0, DOT_LO}) && (w_dr_y <= {5'd0, DOT_HI});
    assign pellet_on = w_d_valid && r_map[w_d_idx] && w_dot_x && w_dot_y;

    logic [9:0] w_hit_idx;
    logic       w_hit;

    assign w_hit_idx = r_valid_q ? r_tile_q : 10'd0;
    assign w_hit     = r_valid_q && r_map[w_hit_idx] && !r_level_clear;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_map         <= '1;
            r_tile_q      <= 10'd0;
            r_valid_q     <= 1'b0;
            r_score       <= 16'h0000;
            r_remaining   <= PELLET_COUNT;
            r_eat         <= 1'b0;
            r_level_clear <= 1'b0;
        end else begin
            r_tile_q <= w_p_tile;
            if (level_restart) begin
                // Restart wins over a coincident hit; the score is kept.
                r_map         <= '1;
                r_remaining   <= PELLET_COUNT;
                r_level_clear <= 1'b0;
                r_eat         <= 1'b0;
                r_valid_q     <= 1'b0;
            end else begin
                r_valid_q <= w_p_valid;
                if (w_hit) begin
                    r_map[w_hit_idx] <= 1'b0;
                    r_remaining      <= r_remaining - 10'd1;
                    r_score          <= bcd_inc(r_score);
                    r_eat            <= 1'b1;
                    if (r_remaining == 10'd1) begin
                        r_level_clear <= 1'b1;
                    end
                end else begin
                    r_eat <= 1'b0;
                end
            end
        end
    end

    assign score_bcd   = r_score;
    assign remaining   = r_remaining;
    assign eat         = r_eat;
    assign level_clear = r_level_clear;

endmodule

// File: tb/tb_pellet_tracker.sv
// Randomized and directed bench for pellet_tracker against a tile-level reference model.
module tb_pellet_tracker;

    localparam logic [9:0] PELLETS = 10'd40;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic        level_restart;
    logic [9:0]  playerX, playerY, drawX, drawY;
    logic        pellet_on;
    logic [15:0] score_bcd;
    logic [9:0]  remaining;
    logic        eat;
    logic        level_clear;

    always #5 frame_clk = ~frame_clk;

    pellet_tracker #(.PELLET_COUNT(PELLETS), .DOT_LO(5'd8), .DOT_HI(5'd11)) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .level_restart(level_restart),
        .playerX      (playerX),
        .playerY      (playerY),
        .drawX        (drawX),
        .drawY        (drawY),
        .pellet_on    (pellet_on),
        .score_bcd    (score_bcd),
        .remaining    (remaining),
        .eat          (eat),
        .level_clear  (level_clear)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: tile bitmap, decimal score, counts.
    bit m_map[768];
    int m_score, m_rem, m_ptile;
    bit m_clear, m_eat, m_pvalid;

    function automatic void model_reset();
        foreach (m_map[i]) m_map[i] = 1'b1;
        m_score  = 0;
        m_rem    = PELLETS;
        m_clear  = 1'b0;
        m_eat    = 1'b0;
        m_pvalid = 1'b0;
        m_ptile  = 0;
    endfunction

    function automatic void model_edge();
        bit hit;
        int x, y;
        if (Reset) begin
            model_reset();
            return;
        end
        x   = playerX;
        y   = playerY;
        hit = m_pvalid && m_map[m_ptile] && !m_clear;
        if (level_restart) begin
            foreach (m_map[i]) m_map[i] = 1'b1;
            m_rem   = PELLETS;
            m_clear = 1'b0;
            m_eat   = 1'b0;
        end else if (hit) begin
            m_map[m_ptile] = 1'b0;
            m_rem--;
            if (m_score < 9999) m_score++;
            m_eat = 1'b1;
            if (m_rem == 0) m_clear = 1'b1;
        end else begin
            m_eat = 1'b0;
        end
        m_pvalid = !level_restart && (x < 640) && (y < 480);
        m_ptile  = m_pvalid ? (y / 20) * 32 + x / 20 : 0;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return 16'((v / 1000) % 10 * 4096 + (v / 100) % 10 * 256 + (v / 10) % 10 * 16 + v % 10);
    endfunction

    function automatic bit exp_pellet(input int dx, input int dy);
        if (dx >= 640 || dy >= 480) return 1'b0;
        return m_map[(dy / 20) * 32 + dx / 20] && (dx % 20 >= 8) && (dx % 20 <= 11)
               && (dy % 20 >= 8) && (dy % 20 <= 11);
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        model_edge();
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_eat"},   32'(eat),         32'(m_eat));
        check({tag, "_score"}, 32'(score_bcd),   32'(to_bcd(m_score)));
        check({tag, "_rem"},   32'(remaining),   32'(m_rem));
        check({tag, "_clear"}, 32'(level_clear), 32'(m_clear));
        check({tag, "_dot"},   32'(pellet_on),   32'(exp_pellet(drawX, drawY)));
    endtask

    task automatic put_tile(input int t);
        playerX = 10'((t % 32) * 20 + $urandom_range(0, 19));
        playerY = 10'(((t / 32) % 24) * 20 + $urandom_range(0, 19));
    endtask

    initial begin
        bit seen100;
        int t, n;

        Reset         = 1'b1;
        level_restart = 1'b0;
        playerX       = 10'd310;
        playerY       = 10'd240;
        drawX         = 10'd308;
        drawY         = 10'd248;
        model_reset();
        #12;
        check_all("reset");
        check("rst_score", 32'(score_bcd), 32'h0000);
        check("rst_rem",   32'(remaining), 32'(PELLETS));
        check("rst_dot",   32'(pellet_on), 32'd1);

        // First pellet: tile 399 eaten at the second edge after release.
        Reset = 1'b0;
        tick();
        check_all("e1");
        check("e1_eat", 32'(eat), 32'd0);
        tick();
        check_all("e2");
        check("e2_eat",   32'(eat),       32'd1);
        check("e2_score", 32'(score_bcd), 32'h0001);
        check("e2_rem",   32'(remaining), 32'(PELLETS - 10'd1));
        repeat (3) begin
            tick();
            check_all("hold");
            check("hold_eat", 32'(eat), 32'd0);
        end
        check("dot_eaten", 32'(pellet_on), 32'd0);
        drawX = 10'd327; #1;
        check("dot_off7", 32'(pellet_on), 32'd0);
        drawX = 10'd328; #1;
        check("dot_fresh", 32'(pellet_on), 32'd1);
        drawY = 10'd485; #1;
        check("dot_yrange", 32'(pellet_on), 32'd0);
        drawX = 10'd645; drawY = 10'd248; #1;
        check("dot_xrange", 32'(pellet_on), 32'd0);

        // Walk right across tiles 399, 400, 401.
        for (int x = 300; x <= 345; x++) begin
            playerX = 10'(x);
            tick();
            check_all("walk");
        end
        tick();
        check_all("walk_end");
        check("walk_score", 32'(score_bcd), 32'h0003);

        // Restart coinciding with a hit on tile 0.
        playerX = 10'd5; playerY = 10'd5;
        tick();
        check_all("pre_rs");
        level_restart = 1'b1;
        tick();
        check_all("rs");
        check("rs_eat",   32'(eat),       32'd0);
        check("rs_rem",   32'(remaining), 32'(PELLETS));
        check("rs_score", 32'(score_bcd), 32'h0003);
        level_restart = 1'b0;
        playerX = 10'd310; playerY = 10'd240;
        tick();
        tick();
        check_all("revisit");
        check("revisit_eat", 32'(eat), 32'd1);

        // Eat every pellet, then keep visiting new tiles.
        for (int i = 0; i < PELLETS + 4; i++) begin
            put_tile(100 + i);
            tick();
            check_all("clr");
        end
        check("clr_flag", 32'(level_clear), 32'd1);
        check("clr_rem",  32'(remaining),   32'd0);
        level_restart = 1'b1;
        tick();
        check_all("clr_rs");
        level_restart = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                playerX = 10'($urandom_range(0, 1023));
                playerY = 10'($urandom_range(0, 1023));
            end else begin
                put_tile($urandom_range(0, 767));
            end
            level_restart = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 0) begin
                drawX = 10'($urandom_range(0, 33) * 20 + $urandom_range(6, 13));
                drawY = 10'($urandom_range(0, 25) * 20 + $urandom_range(6, 13));
            end else begin
                drawX = 10'($urandom_range(0, 1023));
                drawY = 10'($urandom_range(0, 1023));
            end
            tick();
            check_all("rnd");
        end
        level_restart = 1'b0;

        // Reset in the middle of a restart overrides it immediately.
        level_restart = 1'b1;
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        check("arst_score", 32'(score_bcd),   32'h0000);
        check("arst_rem",   32'(remaining),   32'(PELLETS));
        check("arst_eat",   32'(eat),         32'd0);
        check("arst_clear", 32'(level_clear), 32'd0);
        tick();
        check_all("arst_hold");
        Reset = 1'b0;
        level_restart = 1'b0;

        // Drive the score to saturation, restarting whenever the level clears.
        seen100 = 1'b0;
        t = 0;
        n = 0;
        while (!(m_score == 9999 && n > 6) && t < 30000) begin
            if (m_score == 9999) n++;
            put_tile(t);
            level_restart = m_clear;
            tick();
            check("sat_eat",   32'(eat),       32'(m_eat));
            check("sat_score", 32'(score_bcd), 32'(to_bcd(m_score)));
            check("sat_rem",   32'(remaining), 32'(m_rem));
            if (m_score == 100 && !seen100) begin
                seen100 = 1'b1;
                check("carry100", 32'(score_bcd), 32'h0100);
            end
            t++;
        end
        check("sat_reached", 32'(m_score == 9999), 32'd1);
        check("sat_value",   32'(score_bcd),       32'h9999);
        level_restart = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
